// File: rtl/spi_sample_rx.sv
// spi_sample_rx: SPI mode-0 slave receiver for the packed GPS I/Q sample
// stream. Words arrive MSB first; each nibble is {I1,I0,Q1,Q0}. Recovered
// samples are queued in a first-word-fall-through FIFO with valid/ready.
module spi_sample_rx #(
  parameter int unsigned WORD_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        MCU_CLK_25_000,
  input  logic        RESET_P,
  input  logic        SPI_SCK,
  input  logic        SPI_SS,
  input  logic        SPI_MOSI,
  output logic [1:0]  SAMPLE_I,
  output logic [1:0]  SAMPLE_Q,
  output logic        SAMPLE_VALID,
  input  logic        SAMPLE_READY,
  output logic        FRAME_ERR,
  output logic        OVERFLOW,
  output logic [15:0] WORD_COUNT
);

  localparam int unsigned NIBBLES = WORD_BITS / 4;
  localparam int unsigned BW      = $clog2(WORD_BITS);
  localparam int unsigned NW      = $clog2(NIBBLES + 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic sck_s1, sck_s2, sck_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;
  logic sck_rise, ss_rise;

  state_t                 state;
  logic [BW-1:0]          bit_cnt;
  logic [WORD_BITS-2:0]   shift_reg;
  logic [15:0]            word_cnt;
  logic                   frame_err;
  logic                   word_done;
  logic [WORD_BITS-1:0]   next_word;

  logic [WORD_BITS-1:0]   unpack_reg;
  logic [NW-1:0]          nib_cnt;
  logic                   push;
  logic [3:0]             push_data;

  logic [3:0]             mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   fifo_empty, fifo_full, pop, push_ok;
  logic                   overflow;
  logic [3:0]             head;

  // Two-flop synchronizers plus one delay stage for SCK/SS edge detection
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET_P) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= SPI_SCK;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      ss_s1   <= SPI_SS;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
      mosi_s1 <= SPI_MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise  = sck_s2 & ~sck_d;
  assign ss_rise   = ss_s2 & ~ss_d;
  assign next_word = {shift_reg, mosi_s2};
  // SS deassert wins over an SCK rise seen in the same cycle
  assign word_done = (state == ST_ACTIVE) && !ss_rise && sck_rise &&
                     (bit_cnt == BW'(WORD_BITS - 1));

  // Receiver FSM: framing, bit shifting, word counting, frame-error pulse
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET_P) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      word_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (!ss_s2) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            if (bit_cnt != '0) frame_err <= 1'b1;
          end else if (sck_rise) begin
            shift_reg <= next_word[WORD_BITS-2:0];
            if (word_done) begin
              bit_cnt  <= '0;
              word_cnt <= word_cnt + 16'd1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push      = (nib_cnt != '0);
  assign push_data = unpack_reg[WORD_BITS-1 -: 4];

  // Unpacker: one nibble per cycle, MSB nibble first, after each completed word
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET_P) begin
      unpack_reg <= '0;
      nib_cnt    <= '0;
    end else if (word_done) begin
      unpack_reg <= next_word;
      nib_cnt    <= NW'(NIBBLES);
    end else if (push) begin
      unpack_reg <= unpack_reg << 4;
      nib_cnt    <= nib_cnt - 1'b1;
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && SAMPLE_READY;
  assign push_ok    = push && (!fifo_full || pop);

  // Sample FIFO; a push into a full FIFO with a same-cycle pop reuses the freed slot
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET_P) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign head         = mem[rd_ptr[AW-1:0]];
  assign SAMPLE_I     = head[3:2];
  assign SAMPLE_Q     = head[1:0];
  assign SAMPLE_VALID = !fifo_empty;
  assign FRAME_ERR    = frame_err;
  assign OVERFLOW     = overflow;
  assign WORD_COUNT   = word_cnt;

endmodule

// File: tb/tb_spi_sample_rx.sv
// Directed bench for spi_sample_rx with a queue-based model of the sample stream.
module tb_spi_sample_rx;

  localparam int WB    = 8;
  localparam int DEPTH = 4;
  localparam int NIB   = WB / 4;

  logic        clk = 1'b0;
  logic        RESET_P, SPI_SCK, SPI_SS, SPI_MOSI, SAMPLE_READY;
  logic [1:0]  SAMPLE_I, SAMPLE_Q;
  logic        SAMPLE_VALID, FRAME_ERR, OVERFLOW;
  logic [15:0] WORD_COUNT;

  always #5 clk = ~clk;

  spi_sample_rx #(.WORD_BITS(WB), .FIFO_DEPTH(DEPTH)) dut (
    .MCU_CLK_25_000(clk),
    .RESET_P(RESET_P),
    .SPI_SCK(SPI_SCK),
    .SPI_SS(SPI_SS),
    .SPI_MOSI(SPI_MOSI),
    .SAMPLE_I(SAMPLE_I),
    .SAMPLE_Q(SAMPLE_Q),
    .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_READY(SAMPLE_READY),
    .FRAME_ERR(FRAME_ERR),
    .OVERFLOW(OVERFLOW),
    .WORD_COUNT(WORD_COUNT)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  pop_log[$];
  logic [15:0] exp_wc = '0;
  logic        exp_ovf = 1'b0;
  int          exp_fe = 0;
  int          fe_pulses = 0;
  int          fe_cycles = 0;
  logic        fe_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Model: a word yields its nibbles MSB first; with the consumer stalled,
  // nibbles beyond FIFO capacity are lost and OVERFLOW is expected.
  task automatic model_word(input logic [WB-1:0] w, input bit stalled);
    logic [WB-1:0] t;
    exp_wc = exp_wc + 16'd1;
    for (int k = 0; k < NIB; k++) begin
      t = w >> (4 * (NIB - 1 - k));
      if (stalled && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(t[3:0]);
    end
  endtask

  // Pop checker and FRAME_ERR pulse monitor, sampled mid-cycle
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (RESET_P !== 1'b1) begin
        if (FRAME_ERR === 1'b1) begin
          fe_cycles++;
          if (!fe_prev) fe_pulses++;
        end
        fe_prev = (FRAME_ERR === 1'b1);
        if (SAMPLE_VALID === 1'b1 && SAMPLE_READY === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_unexpected: got 0x%0h expected no sample", {SAMPLE_I, SAMPLE_Q});
          end else begin
            e = exp_q.pop_front();
            check("pop_sample", {28'd0, SAMPLE_I, SAMPLE_Q}, {28'd0, e});
          end
          pop_log.push_back({SAMPLE_I, SAMPLE_Q});
        end
      end
    end
  end

  // SCK = clk/4: low two cycles with MOSI set, then high two cycles
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); SPI_SCK = 1'b0; SPI_MOSI = v[i];
      @(negedge clk);
      @(negedge clk); SPI_SCK = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [WB-1:0] w, input bit stalled);
    send_bits(32'(w), WB);
    model_word(w, stalled);
  endtask

  task automatic ss_low();
    @(negedge clk); SPI_SS = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (4) @(negedge clk);
    SPI_SCK = 1'b0;
    SPI_SS  = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); RESET_P = 1'b1; SPI_SS = 1'b1; SPI_SCK = 1'b0;
    @(negedge clk); RESET_P = 1'b0;
    exp_q.delete();
    exp_wc  = '0;
    exp_ovf = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_i"},     32'(SAMPLE_I), 0);
    check({tag, "_q"},     32'(SAMPLE_Q), 0);
    check({tag, "_valid"}, 32'(SAMPLE_VALID), 0);
    check({tag, "_ferr"},  32'(FRAME_ERR), 0);
    check({tag, "_ovf"},   32'(OVERFLOW), 0);
    check({tag, "_wc"},    32'(WORD_COUNT), 0);
  endtask

  task automatic drain_and_check(input string tag, input int n_expected);
    @(negedge clk); SAMPLE_READY = 1'b1;
    repeat (2 * DEPTH + 4) @(negedge clk);
    check({tag, "_pops"}, 32'(pop_log.size()), 32'(n_expected));
    check({tag, "_valid_end"}, 32'(SAMPLE_VALID), 0);
    check({tag, "_model_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_P = 1'b1; SPI_SS = 1'b1; SPI_SCK = 1'b0; SPI_MOSI = 1'b0; SAMPLE_READY = 1'b0;
    repeat (3) @(negedge clk);
    RESET_P = 1'b0;
    #1;
    check_reset_vals("por");

    // SCK activity with SS high must be ignored
    send_bits(32'hFF, 8);
    repeat (6) @(negedge clk);
    check("idle_sck_wc", 32'(WORD_COUNT), 32'(exp_wc));
    check("idle_sck_valid", 32'(SAMPLE_VALID), 0);

    // Single byte 0xB4 with latency pinned relative to the last SCK rise
    SAMPLE_READY = 1'b1;
    pop_log.delete();
    ss_low();
    send_bits(32'hB4, 8);
    #1;
    check("lat_e1_wc", 32'(WORD_COUNT), 32'(exp_wc));
    model_word(8'hB4, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("lat_e3_wc", 32'(WORD_COUNT), 32'h1);
    check("lat_e3_valid", 32'(SAMPLE_VALID), 0);
    @(posedge clk); #1;
    check("lat_e4_valid", 32'(SAMPLE_VALID), 1);
    ss_high();
    check("b4_pops", 32'(pop_log.size()), 2);
    if (pop_log.size() == 2) begin
      check("b4_first", 32'(pop_log[0]), 32'b1011);
      check("b4_second", 32'(pop_log[1]), 32'b0100);
    end
    check("b4_wc", 32'(WORD_COUNT), 32'(exp_wc));
    check("b4_valid_end", 32'(SAMPLE_VALID), 0);
    check("b4_ferr", 32'(fe_pulses), 32'(exp_fe));

    // Backpressure and overflow
    do_reset();
    SAMPLE_READY = 1'b0;
    pop_log.delete();
    ss_low();
    send_word(8'h12, 1'b1);
    send_word(8'h34, 1'b1);
    send_word(8'h56, 1'b1);
    ss_high();
    check("bp_ovf", 32'(OVERFLOW), 32'(exp_ovf));
    check("bp_ovf_lit", 32'(OVERFLOW), 1);
    check("bp_valid", 32'(SAMPLE_VALID), 1);
    check("bp_head", {28'd0, SAMPLE_I, SAMPLE_Q}, 32'h1);
    check("bp_wc", 32'(WORD_COUNT), 32'(exp_wc));
    drain_and_check("bp", 4);
    for (int k = 0; k < pop_log.size(); k++) check("bp_order", 32'(pop_log[k]), 32'(k + 1));

    // Partial word discarded with one FRAME_ERR pulse
    do_reset();
    SAMPLE_READY = 1'b1;
    pop_log.delete();
    ss_low();
    send_bits(32'b10110, 5);
    ss_high();
    exp_fe++;
    check("part_fe_pulses", 32'(fe_pulses), 32'(exp_fe));
    check("part_fe_width", 32'(fe_cycles), 32'(exp_fe));
    check("part_wc", 32'(WORD_COUNT), 32'(exp_wc));
    check("part_no_samples", 32'(pop_log.size()), 0);
    check("part_valid", 32'(SAMPLE_VALID), 0);
    ss_low();
    send_word(8'hA5, 1'b0);
    ss_high();
    check("a5_pops", 32'(pop_log.size()), 2);
    if (pop_log.size() == 2) begin
      check("a5_first", 32'(pop_log[0]), 32'b1010);
      check("a5_second", 32'(pop_log[1]), 32'b0101);
    end
    check("a5_fe_pulses", 32'(fe_pulses), 32'(exp_fe));

    // Full FIFO: READY rises in the cycle nibble 5 is pushed
    do_reset();
    SAMPLE_READY = 1'b0;
    pop_log.delete();
    ss_low();
    send_word(8'h12, 1'b1);
    send_word(8'h34, 1'b1);
    send_bits(32'h56, 8);
    model_word(8'h56, 1'b0);
    @(negedge clk);
    @(negedge clk); SAMPLE_READY = 1'b1;
    @(negedge clk);
    @(negedge clk); SAMPLE_READY = 1'b0;
    ss_high();
    check("sim_ovf", 32'(OVERFLOW), 32'(exp_ovf));
    check("sim_valid", 32'(SAMPLE_VALID), 1);
    check("sim_head", {28'd0, SAMPLE_I, SAMPLE_Q}, 32'h3);
    drain_and_check("sim", 6);
    for (int k = 0; k < pop_log.size(); k++) check("sim_order", 32'(pop_log[k]), 32'(k + 1));
    check("sim_ovf_end", 32'(OVERFLOW), 0);

    // Reset in the middle of a word
    SAMPLE_READY = 1'b1;
    ss_low();
    send_bits(32'b101, 3);
    do_reset();
    #1;
    check_reset_vals("midrst");
    repeat (8) @(negedge clk);
    check("midrst_fe", 32'(fe_pulses), 32'(exp_fe));
    check("midrst_valid", 32'(SAMPLE_VALID), 0);
    pop_log.delete();
    ss_low();
    send_word(8'hFF, 1'b0);
    ss_high();
    check("ff_pops", 32'(pop_log.size()), 2);
    for (int k = 0; k < pop_log.size(); k++) check("ff_val", 32'(pop_log[k]), 32'hF);
    check("ff_wc", 32'(WORD_COUNT), 32'(exp_wc));

    // WORD_COUNT wraps from 0xFFFF to 0
    @(negedge clk);
    force dut.word_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.word_cnt;
    exp_wc = 16'hFFFF;
    #1;
    check("wrap_pre", 32'(WORD_COUNT), 32'(exp_wc));
    ss_low();
    send_word(8'h3C, 1'b0);
    ss_high();
    check("wrap_wc", 32'(WORD_COUNT), 32'(exp_wc));
    check("wrap_wc_lit", 32'(WORD_COUNT), 32'h0);
    check("final_model_empty", 32'(exp_q.size()), 0);
    check("final_fe", 32'(fe_pulses), 32'(exp_fe));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
